// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register: data-memory loads/stores (word/half/byte) and WB-side registers.
// Optional feature macro DM_ALIGN_CHECK_EN: flag and suppress misaligned word/half accesses.
module mem_wb_stage #(
    parameter int          DM_WORDS = 1024,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC_M,
    input  logic [31:0] ALUout_M,
    input  logic [31:0] RT_M,
    input  logic [3:0]  type_M,
    input  logic [1:0]  WRsel_M,
    input  logic [1:0]  WDsel_M,
    input  logic        MemWr_M,
    input  logic        RegWr_M,
    output logic [31:0] IR_W,
    output logic [31:0] PC_W,
    output logic [31:0] ALUout_W,
    output logic [31:0] DMout_W,
    output logic [3:0]  type_W,
    output logic [1:0]  WRsel_W,
    output logic [1:0]  WDsel_W,
    output logic        RegWr_W,
    output logic        align_err_W
);

    localparam int AW = $clog2(DM_WORDS);

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } acc_size_e;

    // Picks the addressed byte/half out of a word and extends it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input acc_size_e size,
                                                 input logic [1:0] off, input logic sign_ext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: res = {{24{sign_ext & b[7]}}, b};
            SZ_HALF: res = {{16{sign_ext & h[15]}}, h};
            SZ_WORD: res = word;
            default: res = word;
        endcase
        return res;
    endfunction

    logic [31:0]   mem_r [DM_WORDS];
    acc_size_e     size_s;
    logic          is_load_s;
    logic          is_store_s;
    logic          sign_s;
    logic [AW-1:0] widx_s;
    logic [1:0]    off_s;
    logic [31:0]   rd_word_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_s;
    logic [31:0]   merged_s;
    logic          align_err_s;
    logic          we_s;
    logic [31:0]   dm_next_s;

    // Opcode decode into access size, direction and signedness.
    always_comb begin
        size_s     = SZ_NONE;
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        sign_s     = 1'b0;
        case (IR_M[31:26])
            6'b100011: begin size_s = SZ_WORD; is_load_s  = 1'b1; end
            6'b100001: begin size_s = SZ_HALF; is_load_s  = 1'b1; sign_s = 1'b1; end
            6'b100101: begin size_s = SZ_HALF; is_load_s  = 1'b1; end
            6'b100000: begin size_s = SZ_BYTE; is_load_s  = 1'b1; sign_s = 1'b1; end
            6'b100100: begin size_s = SZ_BYTE; is_load_s  = 1'b1; end
            6'b101011: begin size_s = SZ_WORD; is_store_s = 1'b1; end
            6'b101001: begin size_s = SZ_HALF; is_store_s = 1'b1; end
            6'b101000: begin size_s = SZ_BYTE; is_store_s = 1'b1; end
            default:   begin size_s = SZ_NONE; end
        endcase
    end

    assign widx_s    = ALUout_M[AW+1:2];
    assign rd_word_s = mem_r[widx_s];

    // Low address bits that are not meaningful for the access size are forced to zero.
    always_comb begin
        off_s = 2'b00;
        case (size_s)
            SZ_BYTE: off_s = ALUout_M[1:0];
            SZ_HALF: off_s = {ALUout_M[1], 1'b0};
            default: off_s = 2'b00;
        endcase
    end

`ifdef DM_ALIGN_CHECK_EN
    logic misalign_s;

    // Word accesses need both low bits clear, half accesses need bit 0 clear.
    always_comb begin
        misalign_s = 1'b0;
        case (size_s)
            SZ_WORD: misalign_s = |ALUout_M[1:0];
            SZ_HALF: misalign_s = ALUout_M[0];
            default: misalign_s = 1'b0;
        endcase
    end

    assign align_err_s = misalign_s;
`else
    assign align_err_s = 1'b0;
`endif

    // Store lane enables and replicated store data.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
        case (size_s)
            SZ_WORD: begin be_s = 4'b1111; wdata_s = RT_M; end
            SZ_HALF: begin
                if (off_s[1]) begin
                    be_s = 4'b1100;
                end else begin
                    be_s = 4'b0011;
                end
                wdata_s = {2{RT_M[15:0]}};
            end
            SZ_BYTE: begin be_s = 4'b0001 << off_s; wdata_s = {4{RT_M[7:0]}}; end
            default: begin be_s = 4'b0000; wdata_s = 32'h0000_0000; end
        endcase
    end

    // Read-modify-write merge keeps the untouched bytes of the word.
    always_comb begin
        merged_s = rd_word_s;
        for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
                merged_s[8*i +: 8] = wdata_s[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = rd_word_s[8*i +: 8];
            end
        end
    end

    assign we_s = MemWr_M & is_store_s & ~align_err_s;

    // Load result; non-loads expose the raw addressed word, faulting accesses return zero.
    always_comb begin
        dm_next_s = 32'h0000_0000;
        if (align_err_s) begin
            dm_next_s = 32'h0000_0000;
        end else if (is_load_s) begin
            dm_next_s = extract_load(rd_word_s, size_s, off_s, sign_s);
        end else begin
            dm_next_s = rd_word_s;
        end
    end

    // Data memory: cleared by reset, a reset cycle never stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (we_s) begin
            mem_r[widx_s] <= merged_s;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            IR_W        <= 32'h0000_0000;
            PC_W        <= PC_RESET;
            ALUout_W    <= 32'h0000_0000;
            DMout_W     <= 32'h0000_0000;
            type_W      <= 4'h0;
            WRsel_W     <= 2'b00;
            WDsel_W     <= 2'b00;
            RegWr_W     <= 1'b0;
            align_err_W <= 1'b0;
        end else begin
            IR_W        <= IR_M;
            PC_W        <= PC_M;
            ALUout_W    <= ALUout_M;
            DMout_W     <= dm_next_s;
            type_W      <= type_M;
            WRsel_W     <= WRsel_M;
            WDsel_W     <= WDsel_M;
            RegWr_W     <= RegWr_M & ~align_err_s;
            align_err_W <= align_err_s;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed and random accesses against a byte-addressed memory model.
module tb_mem_wb_stage;

    localparam int          DMW  = 1024;
    localparam logic [31:0] PCR  = 32'h0000_3000;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_M, PC_M, ALUout_M, RT_M;
    logic [3:0]  type_M;
    logic [1:0]  WRsel_M, WDsel_M;
    logic        MemWr_M, RegWr_M;
    logic [31:0] IR_W, PC_W, ALUout_W, DMout_W;
    logic [3:0]  type_W;
    logic [1:0]  WRsel_W, WDsel_W;
    logic        RegWr_W, align_err_W;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mdl [DMW*4];

    mem_wb_stage #(.DM_WORDS(DMW), .PC_RESET(PCR)) dut (
        .clk(clk), .reset(reset),
        .IR_M(IR_M), .PC_M(PC_M), .ALUout_M(ALUout_M), .RT_M(RT_M),
        .type_M(type_M), .WRsel_M(WRsel_M), .WDsel_M(WDsel_M),
        .MemWr_M(MemWr_M), .RegWr_M(RegWr_M),
        .IR_W(IR_W), .PC_W(PC_W), .ALUout_W(ALUout_W), .DMout_W(DMout_W),
        .type_W(type_W), .WRsel_W(WRsel_W), .WDsel_W(WDsel_W),
        .RegWr_W(RegWr_W), .align_err_W(align_err_W)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One MEM-stage instruction: drive, predict from the model, clock, compare, update model.
    task automatic step(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic mw, input logic rst);
        logic [31:0] rnd, ir, pc, e_dm;
        logic [3:0]  ty;
        logic [1:0]  ws, wd;
        logic        rw, ld, st, sgn, err;
        int unsigned a, sz, base;
        rnd = $urandom();
        ir  = {op, rnd[25:0]};
        pc  = $urandom();
        ty  = 4'($urandom());
        ws  = 2'($urandom());
        wd  = 2'($urandom());
        rw  = 1'($urandom());
        reset = rst; IR_M = ir; PC_M = pc; ALUout_M = addr; RT_M = data;
        type_M = ty; WRsel_M = ws; WDsel_M = wd; MemWr_M = mw; RegWr_M = rw;

        ld = 1'b0; st = 1'b0; sgn = 1'b0; sz = 0;
        case (op)
            OP_LW:  begin ld = 1'b1; sz = 4; end
            OP_LH:  begin ld = 1'b1; sz = 2; sgn = 1'b1; end
            OP_LHU: begin ld = 1'b1; sz = 2; end
            OP_LB:  begin ld = 1'b1; sz = 1; sgn = 1'b1; end
            OP_LBU: begin ld = 1'b1; sz = 1; end
            OP_SW:  begin st = 1'b1; sz = 4; end
            OP_SH:  begin st = 1'b1; sz = 2; end
            OP_SB:  begin st = 1'b1; sz = 1; end
            default: sz = 0;
        endcase
        a   = addr % (DMW * 4);
        err = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
        if (sz > 1 && (a % sz) != 0) err = 1'b1;
`endif
        base = (sz == 0) ? a - (a % 4) : a - (a % sz);
        e_dm = 32'h0;
        if (err) begin
            e_dm = 32'h0;
        end else if (ld) begin
            for (int k = 0; k < int'(sz); k++) e_dm = e_dm | (32'(mdl[base + k]) << (8 * k));
            if (sgn && e_dm[8*sz-1]) e_dm = e_dm | ~((32'd1 << (8 * sz)) - 32'd1);
        end else begin
            for (int k = 0; k < 4; k++) e_dm = e_dm | (32'(mdl[a - (a % 4) + k]) << (8 * k));
        end

        @(posedge clk);
        #1;
        if (rst) begin
            chk("IR_W_rst", IR_W, 32'h0);
            chk("PC_W_rst", PC_W, PCR);
            chk("ALUout_W_rst", ALUout_W, 32'h0);
            chk("DMout_W_rst", DMout_W, 32'h0);
            chk("type_W_rst", 32'(type_W), 32'h0);
            chk("WRsel_W_rst", 32'(WRsel_W), 32'h0);
            chk("WDsel_W_rst", 32'(WDsel_W), 32'h0);
            chk("RegWr_W_rst", 32'(RegWr_W), 32'h0);
            chk("align_err_W_rst", 32'(align_err_W), 32'h0);
            for (int i = 0; i < DMW * 4; i++) mdl[i] = 8'h00;
        end else begin
            chk("IR_W", IR_W, ir);
            chk("PC_W", PC_W, pc);
            chk("ALUout_W", ALUout_W, addr);
            chk("DMout_W", DMout_W, e_dm);
            chk("type_W", 32'(type_W), 32'(ty));
            chk("WRsel_W", 32'(WRsel_W), 32'(ws));
            chk("WDsel_W", 32'(WDsel_W), 32'(wd));
            chk("RegWr_W", 32'(RegWr_W), 32'(rw & ~err));
            chk("align_err_W", 32'(align_err_W), 32'(err));
            if (st && mw && !err)
                for (int k = 0; k < int'(sz); k++) mdl[base + k] = 8'(data >> (8 * k));
        end
    endtask

    initial begin
        logic [5:0] ops [10];
        ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, 6'b000000, 6'b001000};

        for (int i = 0; i < DMW * 4; i++) mdl[i] = 8'h00;

        step(OP_SW, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1);
        step(OP_LW, 32'h10, 32'h0, 1'b0, 1'b0);
        chk("lw10_after_reset", DMout_W, 32'h0);

        step(OP_SW, 32'h20, 32'h1234_5678, 1'b1, 1'b0);
        step(OP_LW, 32'h20, 32'h0, 1'b0, 1'b0);
        chk("sw_then_lw", DMout_W, 32'h1234_5678);

        step(OP_SB, 32'h21, 32'h5555_55AB, 1'b1, 1'b0);
        step(OP_LW, 32'h20, 32'h0, 1'b0, 1'b0);
        chk("sb_merge", DMout_W, 32'h1234_AB78);
        step(OP_LB, 32'h21, 32'h0, 1'b0, 1'b0);
        chk("lb_sext", DMout_W, 32'hFFFF_FFAB);
        step(OP_LBU, 32'h21, 32'h0, 1'b0, 1'b0);
        chk("lbu_zext", DMout_W, 32'h0000_00AB);

        step(OP_SH, 32'h22, 32'h7777_8001, 1'b1, 1'b0);
        step(OP_LH, 32'h22, 32'h0, 1'b0, 1'b0);
        chk("lh_sext", DMout_W, 32'hFFFF_8001);
        step(OP_LHU, 32'h22, 32'h0, 1'b0, 1'b0);
        chk("lhu_zext", DMout_W, 32'h0000_8001);
        step(OP_LW, 32'h20, 32'h0, 1'b0, 1'b0);
        chk("sh_merge", DMout_W, 32'h8001_AB78);

        step(OP_SW, 32'h1000, 32'hCAFE_F00D, 1'b1, 1'b0);
        step(OP_LW, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("addr_wrap", DMout_W, 32'hCAFE_F00D);

        step(6'b000000, 32'h20, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step(OP_SW, 32'h24, 32'h1111_2222, 1'b0, 1'b0);
        step(OP_LW, 32'h20, 32'h0, 1'b0, 1'b0);
        chk("no_write_nonstore", DMout_W, 32'h8001_AB78);

        step(OP_SW, 32'h22, 32'h55AA_33CC, 1'b1, 1'b0);
        step(OP_LW, 32'h20, 32'h0, 1'b0, 1'b0);
`ifdef DM_ALIGN_CHECK_EN
        chk("misaligned_sw_dropped", DMout_W, 32'h8001_AB78);
`else
        chk("misaligned_sw_forced", DMout_W, 32'h55AA_33CC);
`endif

        step(OP_SW, 32'h30, 32'hA5A5_5A5A, 1'b1, 1'b1);
        step(OP_LW, 32'h30, 32'h0, 1'b0, 1'b0);
        chk("reset_drops_store", DMout_W, 32'h0);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] ad;
            ad = $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) ad = ad | (32'($urandom_range(1, 15)) << 12);
            step(ops[$urandom_range(0, 9)], ad, $urandom(), 1'($urandom()),
                 ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
